// File: rtl/riscv_pkg.sv
// Shared core definitions: fetch FSM states, bubble encoding, reset PC and
// the register-field positions used by fetch, decode and the hazard unit.
package riscv_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    HELD  = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  localparam int REG_W   = 5;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int RD_LSB  = 7;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats load, otherwise hold; one-cycle latency.
// A bubble keeps the old PC and replaces the instruction with NOP_INSTR.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] pc_d,
  input  logic [31:0] instr_d,
  output logic [31:0] pc_q,
  output logic [31:0] instr_q,
  output logic        valid_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= 32'h0000_0000;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (bubble) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (load) begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, FETCH/HELD FSM and the stall hold buffer feeding IF/ID.
// One-cycle memory-to-IF/ID latency; STALL holds PC and IF/ID, FLUSH redirects.
module fetch_stage
  import riscv_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic [31:0] BRANCH_TARGET,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_RDATA,
  input  logic        IMEM_READY,
  output logic [31:0] PC_IF_ID,
  output logic [31:0] INSTR_IF_ID,
  output logic        VALID_IF_ID,
  output logic [4:0]  ARS1_IF_ID,
  output logic [4:0]  ARS2_IF_ID,
  output logic [4:0]  ARD_IF_ID
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  hold_buf, hold_buf_nxt;
  logic         ifid_load, ifid_bubble;
  logic [31:0]  ifid_instr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      hold_buf <= 32'h0000_0000;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      hold_buf <= hold_buf_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    hold_buf_nxt = hold_buf;
    ifid_load    = 1'b0;
    ifid_bubble  = 1'b0;
    ifid_instr   = IMEM_RDATA;
    // A redirect always wins; any in-flight or buffered fetch is simply dropped.
    if (FLUSH) begin
      pc_nxt      = BRANCH_TARGET & ~32'h0000_0003;
      ifid_bubble = 1'b1;
      state_nxt   = FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (IMEM_READY && !STALL) begin
            ifid_load = 1'b1;
            pc_nxt    = pc + 32'd4;
          end else if (IMEM_READY) begin
            hold_buf_nxt = IMEM_RDATA;
            state_nxt    = HELD;
          end else if (!STALL) begin
            ifid_bubble = 1'b1;
          end
        end
        HELD: begin
          if (!STALL) begin
            ifid_load  = 1'b1;
            ifid_instr = hold_buf;
            pc_nxt     = pc + 32'd4;
            state_nxt  = FETCH;
          end
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

  assign IMEM_REQ  = (state == FETCH);
  assign IMEM_ADDR = pc;

  if_id_reg u_if_id (
    .clk     (CLK),
    .rst     (RST),
    .load    (ifid_load),
    .bubble  (ifid_bubble),
    .pc_d    (pc),
    .instr_d (ifid_instr),
    .pc_q    (PC_IF_ID),
    .instr_q (INSTR_IF_ID),
    .valid_q (VALID_IF_ID)
  );

  assign ARS1_IF_ID = INSTR_IF_ID[RS1_LSB +: REG_W];
  assign ARS2_IF_ID = INSTR_IF_ID[RS2_LSB +: REG_W];
  assign ARD_IF_ID  = INSTR_IF_ID[RD_LSB  +: REG_W];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then randomized stimulus against a behavioural model.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        STALL = 1'b0;
  logic        FLUSH = 1'b0;
  logic [31:0] BRANCH_TARGET = 32'h0;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_RDATA;
  logic        IMEM_READY = 1'b1;
  logic [31:0] PC_IF_ID;
  logic [31:0] INSTR_IF_ID;
  logic        VALID_IF_ID;
  logic [4:0]  ARS1_IF_ID;
  logic [4:0]  ARS2_IF_ID;
  logic [4:0]  ARD_IF_ID;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  fetch_stage dut (
    .CLK           (CLK),
    .RST           (RST),
    .STALL         (STALL),
    .FLUSH         (FLUSH),
    .BRANCH_TARGET (BRANCH_TARGET),
    .IMEM_REQ      (IMEM_REQ),
    .IMEM_ADDR     (IMEM_ADDR),
    .IMEM_RDATA    (IMEM_RDATA),
    .IMEM_READY    (IMEM_READY),
    .PC_IF_ID      (PC_IF_ID),
    .INSTR_IF_ID   (INSTR_IF_ID),
    .VALID_IF_ID   (VALID_IF_ID),
    .ARS1_IF_ID    (ARS1_IF_ID),
    .ARS2_IF_ID    (ARS2_IF_ID),
    .ARD_IF_ID     (ARD_IF_ID)
  );

  // Instruction memory contents as a pure function of address; word 4 is add x3,x1,x2.
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h4) return 32'h0020_81B3;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  assign IMEM_RDATA = memf(IMEM_ADDR);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: next fetch address, an optional parked word, and IF/ID contents.
  logic [31:0] m_pc = 32'h0;
  logic        m_parked = 1'b0;
  logic [31:0] m_parked_word = 32'h0;
  logic [31:0] m_ifpc = 32'h0;
  logic [31:0] m_ifinstr = 32'h13;
  logic        m_ifvalid = 1'b0;
  logic        m_init = 1'b0;

  always @(posedge CLK) begin
    if (RST) begin
      m_pc = 32'h0; m_parked = 1'b0; m_parked_word = 32'h0;
      m_ifpc = 32'h0; m_ifinstr = 32'h13; m_ifvalid = 1'b0; m_init = 1'b1;
    end else if (FLUSH) begin
      m_pc = {BRANCH_TARGET[31:2], 2'b00};
      m_parked = 1'b0;
      m_ifinstr = 32'h13; m_ifvalid = 1'b0;
    end else if (m_parked) begin
      if (!STALL) begin
        m_ifpc = m_pc; m_ifinstr = m_parked_word; m_ifvalid = 1'b1;
        m_pc = m_pc + 32'd4; m_parked = 1'b0;
      end
    end else if (IMEM_READY) begin
      if (STALL) begin
        m_parked = 1'b1; m_parked_word = memf(m_pc);
      end else begin
        m_ifpc = m_pc; m_ifinstr = memf(m_pc); m_ifvalid = 1'b1;
        m_pc = m_pc + 32'd4;
      end
    end else if (!STALL) begin
      m_ifinstr = 32'h13; m_ifvalid = 1'b0;
    end
  end

  // Compare process: every cycle once reset has been applied.
  always @(negedge CLK) begin
    if (m_init) begin
      chk("imem_req",  {31'b0, IMEM_REQ},    {31'b0, !m_parked});
      chk("imem_addr", IMEM_ADDR,            m_pc);
      chk("pc_if_id",  PC_IF_ID,             m_ifpc);
      chk("instr",     INSTR_IF_ID,          m_ifinstr);
      chk("valid",     {31'b0, VALID_IF_ID}, {31'b0, m_ifvalid});
      chk("ars1",      {27'b0, ARS1_IF_ID},  {27'b0, m_ifinstr[19:15]});
      chk("ars2",      {27'b0, ARS2_IF_ID},  {27'b0, m_ifinstr[24:20]});
      chk("ard",       {27'b0, ARD_IF_ID},   {27'b0, m_ifinstr[11:7]});
      if (VALID_IF_ID)
        chk("stream_word", INSTR_IF_ID, memf(PC_IF_ID));
    end
  end

  task automatic step(input logic rst, input logic stall, input logic flush,
                      input logic [31:0] tgt, input logic ready);
    RST = rst; STALL = stall; FLUSH = flush; BRANCH_TARGET = tgt; IMEM_READY = ready;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset
    step(1, 0, 0, 0, 1);
    step(1, 1, 1, 32'h40, 1);
    chk("rst_addr",  IMEM_ADDR, 32'h0);
    chk("rst_req",   {31'b0, IMEM_REQ}, 32'h1);
    chk("rst_valid", {31'b0, VALID_IF_ID}, 32'h0);
    chk("rst_instr", INSTR_IF_ID, 32'h13);
    chk("rst_pc",    PC_IF_ID, 32'h0);

    // Streaming fetch
    step(0, 0, 0, 0, 1);
    chk("s0_pc", PC_IF_ID, 32'h0);
    chk("s0_addr", IMEM_ADDR, 32'h4);
    step(0, 0, 0, 0, 1);
    chk("s1_pc", PC_IF_ID, 32'h4);
    chk("s1_ars1", {27'b0, ARS1_IF_ID}, 32'd1);
    chk("s1_ars2", {27'b0, ARS2_IF_ID}, 32'd2);
    chk("s1_ard",  {27'b0, ARD_IF_ID},  32'd3);
    chk("s1_addr", IMEM_ADDR, 32'h8);

    // Stall with data returning at PC=8
    step(0, 1, 0, 0, 1);
    chk("st0_req", {31'b0, IMEM_REQ}, 32'h0);
    chk("st0_pc",  PC_IF_ID, 32'h4);
    step(0, 1, 0, 0, 1);
    chk("st1_pc",  PC_IF_ID, 32'h4);
    step(0, 0, 0, 0, 1);
    chk("st2_pc",    PC_IF_ID, 32'h8);
    chk("st2_valid", {31'b0, VALID_IF_ID}, 32'h1);
    chk("st2_addr",  IMEM_ADDR, 32'hC);
    step(0, 0, 0, 0, 1);

    // Memory wait at PC=16
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      chk("wait_valid", {31'b0, VALID_IF_ID}, 32'h0);
      chk("wait_instr", INSTR_IF_ID, 32'h13);
      chk("wait_addr",  IMEM_ADDR, 32'h10);
    end
    step(0, 0, 0, 0, 1);
    chk("wait_done_pc", PC_IF_ID, 32'h10);

    // Flush beats stall; target low bits cleared
    step(0, 1, 1, 32'h0000_0103, 1);
    chk("fl_addr",  IMEM_ADDR, 32'h100);
    chk("fl_valid", {31'b0, VALID_IF_ID}, 32'h0);
    chk("fl_req",   {31'b0, IMEM_REQ}, 32'h1);

    // Flush while HELD drops the parked word
    step(0, 1, 0, 0, 1);
    step(0, 0, 1, 32'h200, 0);
    step(0, 0, 0, 0, 1);
    chk("flh_pc", PC_IF_ID, 32'h200);
    chk("flh_valid", {31'b0, VALID_IF_ID}, 32'h1);

    // Reset while HELD
    step(0, 1, 0, 0, 1);
    step(1, 1, 0, 0, 1);
    chk("rh_req",   {31'b0, IMEM_REQ}, 32'h1);
    chk("rh_addr",  IMEM_ADDR, 32'h0);
    chk("rh_valid", {31'b0, VALID_IF_ID}, 32'h0);

    // PC wrap-around
    step(0, 0, 1, 32'hFFFF_FFFF, 1);
    chk("wr_addr0", IMEM_ADDR, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 1);
    chk("wr_pc",    PC_IF_ID, 32'hFFFF_FFFC);
    chk("wr_addr1", IMEM_ADDR, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(199, 0) == 0,
           $urandom_range(99, 0) < 25,
           $urandom_range(99, 0) < 8,
           $urandom,
           $urandom_range(99, 0) < 70);
    end
    step(0, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
